// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixed up in FINISH.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    input  logic            hilo_rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Upper half: partial product / remainder. Lower half: multiplier / quotient.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              div_zero_q, div_zero_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              op_signed;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign op_signed = ~op_i[0] & ~op_i[2];
    assign sign_a    = op_signed & rs_data_i[XLEN-1];
    assign sign_b    = op_signed & rt_data_i[XLEN-1];
    assign mag_a     = sign_a ? -rs_data_i : rs_data_i;
    assign mag_b     = sign_b ? -rt_data_i : rt_data_i;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb_q};
    // Trial MSB set means the shifted remainder was below the divisor: restore.
    assign div_next  = div_trial[XLEN]
                     ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   rem_abs, quo_abs;

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign rem_abs  = acc_q[2*XLEN-1:XLEN];
    assign quo_abs  = acc_q[XLEN-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (op_i <= 3'd3) begin
                        state_d    = StCalc;
                        cnt_d      = CntW'(XLEN);
                        is_div_d   = op_i[1];
                        neg_lo_d   = sign_a ^ sign_b;
                        neg_hi_d   = sign_a;
                        div_zero_d = op_i[1] && (rt_data_i == '0);
                        if (op_i[1]) begin
                            acc_d = {{XLEN{1'b0}}, mag_a};
                            opb_d = mag_b;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, mag_b};
                            opb_d = mag_a;
                        end
                    end else if (op_i == 3'd4) begin
                        hi_d = rs_data_i;
                    end else if (op_i == 3'd5) begin
                        lo_d = rs_data_i;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntW'(1);
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == CntW'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
                if (is_div_q) begin
                    hi_d = neg_hi_q ? -rem_abs : rem_abs;
                    lo_d = div_zero_q ? '1 : (neg_lo_q ? -quo_abs : quo_abs);
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush beats everything, including MTHI/MTLO and the FINISH write.
        if (flush_i) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign stall_o = busy_o & (start_i | hilo_rd_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues per-cycle expectations from an
// arithmetic reference model, and a monitor compares them against the DUT.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs, rt;
    logic         hilo_rd;
    logic         flush;
    logic         busy, stall;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.XLEN(W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .op_i      (op),
        .rs_data_i (rs),
        .rt_data_i (rt),
        .hilo_rd_i (hilo_rd),
        .flush_i   (flush),
        .busy_o    (busy),
        .stall_o   (stall),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           due;
        string        name;
        logic         busy;
        logic         stall;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: plain language arithmetic on the architectural result.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, b,
                                  input logic [W-1:0] h0, l0,
                                  output logic [W-1:0] h, l);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0]        up;
        h = h0;
        l = l0;
        case (o)
            3'd0: begin
                sp = $signed(a) * $signed(b);
                h  = sp[2*W-1:W];
                l  = sp[W-1:0];
            end
            3'd1: begin
                up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                h  = up[2*W-1:W];
                l  = up[W-1:0];
            end
            3'd2: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else if (a == MIN && b == '1) begin
                    h = '0;
                    l = MIN;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    task automatic expect_at(input int d, input string nm, input logic b, s,
                             input logic [W-1:0] h, l);
        exp_t e;
        e.due = d; e.name = nm; e.busy = b; e.stall = s; e.hi = h; e.lo = l;
        q.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [W-1:0] act, req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has set this cycle's inputs.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.late: due %0d, seen %0d", e.name, e.due, cyc);
            end else begin
                cmp({e.name, ".busy"},  W'(busy),  W'(e.busy));
                cmp({e.name, ".stall"}, W'(stall), W'(e.stall));
                cmp({e.name, ".hi"},    hi,        e.hi);
                cmp({e.name, ".lo"},    lo,        e.lo);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b, output int acc);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b; hilo_rd = 1'b0; flush = 1'b0;
        expect_at(cyc, "issue", 1'b0, 1'b0, m_hi, m_lo);
        acc = cyc + 1;
    endtask

    // Follows one accepted op (accept edge acc) cycle by cycle until it retires or aborts.
    task automatic track(input int acc, input logic [2:0] o, input logic [W-1:0] a, b,
                         input bit rd, input int abort_at, input bit use_rst,
                         input int hold_from, input logic [W-1:0] ha, hb, input string nm);
        logic [W-1:0] nh, nl;
        model(o, a, b, m_hi, m_lo, nh, nl);
        if (o >= 3'd4) begin
            @(negedge clk);
            start = 1'b0;
            m_hi = nh;
            m_lo = nl;
            expect_at(cyc, nm, 1'b0, 1'b0, m_hi, m_lo);
            return;
        end
        for (int d = acc; d <= acc + W + 1; d++) begin
            @(negedge clk);
            if (hold_from > 0 && d >= hold_from) begin
                start = 1'b1; op = 3'd0; rs = ha; rt = hb;
            end else begin
                start = 1'b0;
            end
            hilo_rd = rd;
            if (d == abort_at && use_rst) begin
                rst_n = 1'b0;
                m_hi = '0;
                m_lo = '0;
                expect_at(cyc, {nm, ".rst"}, 1'b0, 1'b0, m_hi, m_lo);
                @(negedge clk);
                rst_n = 1'b1;
                hilo_rd = 1'b0;
                expect_at(cyc, {nm, ".rst_rel"}, 1'b0, 1'b0, m_hi, m_lo);
                return;
            end
            if (d == abort_at) begin
                flush = 1'b1;
                expect_at(cyc, nm, 1'b1, rd, m_hi, m_lo);
                @(negedge clk);
                flush = 1'b0;
                hilo_rd = 1'b0;
                expect_at(cyc, {nm, ".flushed"}, 1'b0, 1'b0, m_hi, m_lo);
                return;
            end
            if (d <= acc + W) begin
                expect_at(cyc, nm, 1'b1, rd | start, m_hi, m_lo);
            end else begin
                m_hi = nh;
                m_lo = nl;
                expect_at(cyc, {nm, ".done"}, 1'b0, 1'b0, m_hi, m_lo);
            end
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, b, input string nm,
                       input bit rd, input int off, input bit use_rst);
        int acc;
        issue(o, a, b, acc);
        track(acc, o, a, b, rd, (off < 0) ? -1 : acc + off, use_rst, 0, '0, '0, nm);
    endtask

    task automatic flush_start(input logic [2:0] o, input logic [W-1:0] a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b; flush = 1'b1; hilo_rd = 1'b0;
        expect_at(cyc, "flush_start", 1'b0, 1'b0, m_hi, m_lo);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        expect_at(cyc, "flush_start.after", 1'b0, 1'b0, m_hi, m_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return MIN;
            4:       return MAX;
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        int acc1;
        logic [2:0] o;
        rst_n = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0; hilo_rd = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc, "reset", 1'b0, 1'b0, '0, '0);

        run(3'd4, 32'hA5A5A5A5, '0, "mthi", 1'b0, -1, 1'b0);
        run(3'd5, 32'h5A5A5A5A, '0, "mtlo", 1'b0, -1, 1'b0);
        run(3'd6, 32'h11111111, 32'h2, "rsvd6", 1'b0, -1, 1'b0);
        run(3'd7, 32'h22222222, 32'h3, "rsvd7", 1'b0, -1, 1'b0);

        run(3'd0, 32'hFFFFFFFD, 32'd7, "mult", 1'b0, -1, 1'b0);
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu", 1'b0, -1, 1'b0);
        run(3'd2, 32'hFFFFFFF9, 32'd2, "div", 1'b0, -1, 1'b0);
        run(3'd3, 32'd100, 32'd7, "divu", 1'b0, -1, 1'b0);
        run(3'd2, MIN, 32'hFFFFFFFF, "div_ovf", 1'b0, -1, 1'b0);
        run(3'd3, 32'h12345678, '0, "divu_zero", 1'b0, -1, 1'b0);
        run(3'd2, 32'hFFFF0000, '0, "div_zero", 1'b0, -1, 1'b0);

        // MULT followed by MFHI in the next cycle.
        run(3'd0, 32'h00012345, 32'hFFFF0003, "mult_mfhi", 1'b1, -1, 1'b0);

        // Second MULT presented at busy cycle 5, held in EX until IDLE.
        issue(3'd0, 32'h0000BEEF, 32'h00000100, acc1);
        track(acc1, 3'd0, 32'h0000BEEF, 32'h00000100, 1'b0, -1, 1'b0, acc1 + 4,
              32'h80000000, 32'h00000003, "mult_hold");
        track(acc1 + W + 2, 3'd0, 32'h80000000, 32'h00000003, 1'b0, -1, 1'b0, 0, '0, '0,
              "mult_second");

        run(3'd3, 32'hDEADBEEF, 32'd13, "flush_calc", 1'b0, 10, 1'b0);
        run(3'd3, 32'hDEADBEEF, 32'd13, "flush_finish", 1'b1, W, 1'b0);
        run(3'd3, 32'hDEADBEEF, 32'd13, "rst_calc", 1'b0, 15, 1'b1);

        run(3'd4, 32'hCAFEF00D, '0, "mthi2", 1'b0, -1, 1'b0);
        flush_start(3'd4, 32'h01010101, '0);
        flush_start(3'd5, 32'h02020202, '0);
        flush_start(3'd0, 32'h7, 32'h9);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) o = 3'($urandom_range(4, 7));
            else                           o = 3'($urandom_range(0, 3));
            run(o, pick(), pick(), "rand", 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        @(negedge clk);
        start = 1'b0; hilo_rd = 1'b0; flush = 1'b0;
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        #3;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad += q.size();
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
